visor_inject_port: RTL

Target-side responder for the debugging supervisor's instruction-injection protocol. It sits between the target Synapse316's fetch port and its code ROM. Normally it passes fetches straight through. On command from the supervisor, it waits for a clean fetch boundary and feeds a queued burst of supervisor instructions into the target. It then stalls the target for a fixed drain period and captures `tg_to_visor_reg`, so the supervisor can read registers and restore the target.

---
 rtl/visor_inject_port.sv | 124 ++++++++++++
 1 files changed

// File: rtl/visor_inject_port.sv
// visor_inject_port: target-side responder for supervisor instruction injection.
// Passes ROM fetches through to the target. On command it waits for a clean
// fetch boundary, feeds the queued burst into the target, stalls it for a
// fixed drain period and captures the target's export register.
module visor_inject_port #(
    parameter int INJ_DEPTH    = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        sysclk,
    input  logic        sysreset,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_code_in,
    input  logic        rom_code_ready,
    input  logic [15:0] tg_code_addr,
    output logic [15:0] tg_code_in,
    output logic        tg_code_ready,
    input  logic [15:0] tg_to_visor_reg,
    input  logic [15:0] inj_word,
    input  logic        inj_valid,
    output logic        inj_ready,
    input  logic        inj_flush,
    input  logic        inj_go,
    output logic        inj_busy,
    output logic        inj_done,
    output logic [15:0] cap_data,
    output logic [15:0] resume_addr
);
    localparam int PW = $clog2(INJ_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(INJ_DEPTH);

    typedef enum logic [1:0] {PASS, ARM, INJECT, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [15:0]   queue [INJ_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [DW-1:0] drain_cnt;
    logic          enq, pop, flush, last_pop, drain_end;

    assign rom_addr  = tg_code_addr;
    assign inj_busy  = (state != PASS);
    assign last_pop  = (state == INJECT) && (count == CW'(1));
    assign drain_end = (state == DRAIN) && (drain_cnt == DW'(1));

    // State register
    always_ff @(posedge sysclk) begin
        if (!sysreset) state <= PASS;
        else           state <= state_nxt;
    end

    // Next-state, fetch-port muxing and queue handshake
    always_comb begin
        state_nxt     = state;
        tg_code_in    = rom_code_in;
        tg_code_ready = rom_code_ready;
        inj_ready     = 1'b0;
        enq           = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        unique case (state)
            PASS: begin
                inj_ready = (count < DEPTH_C);
                flush     = inj_flush;
                // Flush wins over both enqueue and go in the same cycle.
                enq       = inj_valid && inj_ready && !inj_flush;
                if (inj_go && !inj_flush && (count != '0)) state_nxt = ARM;
            end
            ARM: begin
                // Target consumes this ROM word; the burst follows it.
                if (rom_code_ready) state_nxt = INJECT;
            end
            INJECT: begin
                tg_code_in    = queue[head];
                tg_code_ready = 1'b1;
                pop           = 1'b1;
                if (last_pop) state_nxt = DRAIN;
            end
            DRAIN: begin
                tg_code_in    = '0;
                tg_code_ready = 1'b0;
                if (drain_end) state_nxt = PASS;
            end
            default: state_nxt = PASS;
        endcase
    end

    // Queue pointers and occupancy; enqueue and pop never share a cycle
    always_ff @(posedge sysclk) begin
        if (!sysreset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (enq) begin
            tail  <= tail + PW'(1);
            count <= count + CW'(1);
        end else if (pop) begin
            head  <= head + PW'(1);
            count <= count - CW'(1);
        end
    end

    // Queue storage, unreset
    always_ff @(posedge sysclk) begin
        if (enq) queue[tail] <= inj_word;
    end

    // Resume address, drain counter, capture and done pulse
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            resume_addr <= '0;
            drain_cnt   <= '0;
            cap_data    <= '0;
            inj_done    <= 1'b0;
        end else begin
            inj_done <= drain_end;
            if (state == ARM && rom_code_ready) resume_addr <= tg_code_addr + 16'd1;
            if (last_pop)                 drain_cnt <= DW'(DRAIN_CYCLES);
            else if (state == DRAIN)      drain_cnt <= drain_cnt - DW'(1);
            if (drain_end) cap_data <= tg_to_visor_reg;
        end
    end
endmodule
